// File: rtl/tcm_lsu_pkg.sv
// Shared types and helpers for the TCM load/store unit.
package tcm_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RESP
    } lsu_state_t;

    // True for the illegal size code or an access not aligned to its own size.
    function automatic logic lsu_bad_shape(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'd0:    return 1'b0;
            2'd1:    return lo[0];
            2'd2:    return lo != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/tcm_lsu_if.sv
// Request/response handshake plus the TCM data-port bus of the load/store unit.
interface tcm_lsu_if #(
    parameter int MEM_ADDR_WIDTH = 8
);
    logic                      i_req_valid;
    logic                      o_req_ready;
    logic [31:0]               i_req_addr;
    logic                      i_req_write;
    logic [1:0]                i_req_size;
    logic                      i_req_unsigned;
    logic [31:0]               i_req_wdata;
    logic                      o_rsp_valid;
    logic                      i_rsp_ready;
    logic [31:0]               o_rsp_rdata;
    logic                      o_rsp_error;
    logic [MEM_ADDR_WIDTH-1:0] o_tcm_addr;
    logic [3:0]                o_tcm_write;
    logic [31:0]               o_tcm_data;
    logic [31:0]               i_tcm_data;

    modport master (
        output i_req_valid, i_req_addr, i_req_write, i_req_size, i_req_unsigned,
        output i_req_wdata, i_rsp_ready, i_tcm_data,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_error,
        input  o_tcm_addr, o_tcm_write, o_tcm_data
    );

    modport slave (
        input  i_req_valid, i_req_addr, i_req_write, i_req_size, i_req_unsigned,
        input  i_req_wdata, i_rsp_ready, i_tcm_data,
        output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_error,
        output o_tcm_addr, o_tcm_write, o_tcm_data
    );

endinterface

// File: rtl/tcm_lsu_align.sv
// Byte-lane steering: store strobes/replication and load extract/extend.
module tcm_lsu_align
    import tcm_lsu_pkg::*;
(
    input  logic [1:0]  st_addr_lo,
    input  lsu_size_t   st_size,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_strb,
    output logic [31:0] st_data,
    input  logic [1:0]  ld_addr_lo,
    input  lsu_size_t   ld_size,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_raw,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_strb = '0;
        st_data = st_wdata;
        case (st_size)
            SZ_BYTE: begin
                st_strb = 4'b0001 << st_addr_lo;
                st_data = {4{st_wdata[7:0]}};
            end
            SZ_HALF: begin
                st_strb = st_addr_lo[1] ? 4'b1100 : 4'b0011;
                st_data = {2{st_wdata[15:0]}};
            end
            SZ_WORD: st_strb = 4'b1111;
            default: st_strb = '0;
        endcase
    end

    always_comb begin
        ld_byte = ld_raw[{ld_addr_lo, 3'b000} +: 8];
        ld_half = ld_addr_lo[1] ? ld_raw[31:16] : ld_raw[15:0];
        case (ld_size)
            SZ_BYTE: ld_data = {{24{ld_byte[7] & ~ld_unsigned}}, ld_byte};
            SZ_HALF: ld_data = {{16{ld_half[15] & ~ld_unsigned}}, ld_half};
            default: ld_data = ld_raw;
        endcase
    end

endmodule

// File: rtl/tcm_lsu.sv
// Single-outstanding load/store initiator for the TCM data port.
module tcm_lsu
    import tcm_lsu_pkg::*;
#(
    parameter int          MEM_ADDR_WIDTH = 8,
    parameter logic [31:0] TCM_BASE       = 32'h0000_0000
) (
    input  logic      i_clk,
    input  logic      i_reset,
    tcm_lsu_if.slave  bus
);

    localparam int HI_LSB = MEM_ADDR_WIDTH + 2;

    lsu_state_t                state;
    logic                      rsp_valid_q;
    logic [31:0]               rsp_rdata_q;
    logic                      rsp_error_q;
    logic [MEM_ADDR_WIDTH-1:0] tcm_addr_q;
    logic [3:0]                tcm_write_q;
    logic [31:0]               tcm_data_q;
    logic [1:0]                lat_lo;
    lsu_size_t                 lat_size;
    logic                      lat_unsigned;
    logic                      lat_write;

    logic                      req_err;
    logic [3:0]                st_strb;
    logic [31:0]               st_data;
    logic [31:0]               ld_data;

    assign req_err = lsu_bad_shape(bus.i_req_size, bus.i_req_addr[1:0])
                   | (bus.i_req_addr[31:HI_LSB] != TCM_BASE[31:HI_LSB]);

    tcm_lsu_align u_align (
        .st_addr_lo  (bus.i_req_addr[1:0]),
        .st_size     (lsu_size_t'(bus.i_req_size)),
        .st_wdata    (bus.i_req_wdata),
        .st_strb     (st_strb),
        .st_data     (st_data),
        .ld_addr_lo  (lat_lo),
        .ld_size     (lat_size),
        .ld_unsigned (lat_unsigned),
        .ld_raw      (bus.i_tcm_data),
        .ld_data     (ld_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= IDLE;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_error_q  <= 1'b0;
            tcm_addr_q   <= '0;
            tcm_write_q  <= '0;
            tcm_data_q   <= '0;
            lat_lo       <= '0;
            lat_size     <= SZ_BYTE;
            lat_unsigned <= 1'b0;
            lat_write    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_req_valid) begin
                        if (req_err) begin
                            rsp_valid_q <= 1'b1;
                            rsp_error_q <= 1'b1;
                            rsp_rdata_q <= '0;
                            state       <= RESP;
                        end else begin
                            tcm_addr_q   <= bus.i_req_addr[MEM_ADDR_WIDTH+1:2];
                            if (bus.i_req_write) begin
                                tcm_write_q <= st_strb;
                                tcm_data_q  <= st_data;
                            end
                            lat_lo       <= bus.i_req_addr[1:0];
                            lat_size     <= lsu_size_t'(bus.i_req_size);
                            lat_unsigned <= bus.i_req_unsigned;
                            lat_write    <= bus.i_req_write;
                            state        <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    tcm_write_q <= '0;
                    if (lat_write) begin
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= 1'b0;
                        rsp_rdata_q <= '0;
                        state       <= RESP;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    rsp_valid_q <= 1'b1;
                    rsp_error_q <= 1'b0;
                    rsp_rdata_q <= ld_data;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.i_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_req_ready = (state == IDLE) & ~i_reset;
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_rdata = rsp_rdata_q;
    assign bus.o_rsp_error = rsp_error_q;
    assign bus.o_tcm_addr  = tcm_addr_q;
    assign bus.o_tcm_write = tcm_write_q;
    assign bus.o_tcm_data  = tcm_data_q;

endmodule

// File: tb/tb_tcm_lsu.sv
// Directed bench for tcm_lsu with a one-cycle-latency byte-writable TCM model.
module tb_tcm_lsu;
    import tcm_lsu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    tcm_lsu_if #(.MEM_ADDR_WIDTH(8)) bus ();

    tcm_lsu #(
        .MEM_ADDR_WIDTH (8),
        .TCM_BASE       (32'h0000_0000)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else begin
            for (int b = 0; b < 4; b++)
                if (bus.o_tcm_write[b]) mem[bus.o_tcm_addr][8*b +: 8] <= bus.o_tcm_data[8*b +: 8];
        end
        bus.i_tcm_data <= mem[bus.o_tcm_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge in IDLE; returns at the negedge of cycle T+1.
    task automatic req(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic uns);
        bus.i_req_valid    = 1'b1;
        bus.i_req_write    = wr;
        bus.i_req_size     = sz;
        bus.i_req_addr     = addr;
        bus.i_req_wdata    = wdata;
        bus.i_req_unsigned = uns;
        chk("req_ready", {31'd0, bus.o_req_ready}, 32'd1);
        @(negedge clk);
        bus.i_req_valid = 1'b0;
    endtask

    task automatic store_chk(input string tag, input logic [1:0] sz, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] e_addr,
                             input logic [3:0] e_strb, input logic [31:0] e_data);
        req(1'b1, sz, addr, wdata, 1'b0);
        chk({tag, "_addr"}, {24'd0, bus.o_tcm_addr}, e_addr);
        chk({tag, "_strb"}, {28'd0, bus.o_tcm_write}, {28'd0, e_strb});
        chk({tag, "_data"}, bus.o_tcm_data, e_data);
        chk({tag, "_nvalid"}, {31'd0, bus.o_rsp_valid}, 32'd0);
        @(negedge clk);
        chk({tag, "_strb_off"}, {28'd0, bus.o_tcm_write}, 32'd0);
        chk({tag, "_valid"}, {31'd0, bus.o_rsp_valid}, 32'd1);
        chk({tag, "_err"}, {31'd0, bus.o_rsp_error}, 32'd0);
        chk({tag, "_rdata"}, bus.o_rsp_rdata, 32'd0);
        @(negedge clk);
        chk({tag, "_done"}, {31'd0, bus.o_rsp_valid}, 32'd0);
    endtask

    task automatic load_chk(input string tag, input logic [1:0] sz, input logic [31:0] addr,
                            input logic uns, input logic [31:0] e_rdata);
        req(1'b0, sz, addr, 32'h0, uns);
        chk({tag, "_addr"}, {24'd0, bus.o_tcm_addr}, {24'd0, addr[9:2]});
        chk({tag, "_nostrb"}, {28'd0, bus.o_tcm_write}, 32'd0);
        @(negedge clk);
        chk({tag, "_nvalid"}, {31'd0, bus.o_rsp_valid}, 32'd0);
        @(negedge clk);
        chk({tag, "_valid"}, {31'd0, bus.o_rsp_valid}, 32'd1);
        chk({tag, "_err"}, {31'd0, bus.o_rsp_error}, 32'd0);
        chk({tag, "_rdata"}, bus.o_rsp_rdata, e_rdata);
        @(negedge clk);
        chk({tag, "_done"}, {31'd0, bus.o_rsp_valid}, 32'd0);
    endtask

    task automatic err_chk(input string tag, input logic wr, input logic [1:0] sz,
                           input logic [31:0] addr, input logic [31:0] hold_addr);
        req(wr, sz, addr, 32'hFFFF_FFFF, 1'b0);
        chk({tag, "_valid"}, {31'd0, bus.o_rsp_valid}, 32'd1);
        chk({tag, "_err"}, {31'd0, bus.o_rsp_error}, 32'd1);
        chk({tag, "_rdata"}, bus.o_rsp_rdata, 32'd0);
        chk({tag, "_nostrb"}, {28'd0, bus.o_tcm_write}, 32'd0);
        chk({tag, "_hold"}, {24'd0, bus.o_tcm_addr}, hold_addr);
        @(negedge clk);
        chk({tag, "_done"}, {31'd0, bus.o_rsp_valid}, 32'd0);
        chk({tag, "_nostrb2"}, {28'd0, bus.o_tcm_write}, 32'd0);
    endtask

    initial begin
        bus.i_req_valid    = 1'b0;
        bus.i_req_write    = 1'b0;
        bus.i_req_size     = 2'd0;
        bus.i_req_addr     = '0;
        bus.i_req_wdata    = '0;
        bus.i_req_unsigned = 1'b0;
        bus.i_rsp_ready    = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, bus.o_req_ready}, 32'd0);
        chk("rst_valid", {31'd0, bus.o_rsp_valid}, 32'd0);
        chk("rst_rdata", bus.o_rsp_rdata, 32'd0);
        chk("rst_err", {31'd0, bus.o_rsp_error}, 32'd0);
        chk("rst_strb", {28'd0, bus.o_tcm_write}, 32'd0);
        chk("rst_addr", {24'd0, bus.o_tcm_addr}, 32'd0);
        chk("rst_data", bus.o_tcm_data, 32'd0);
        rst = 1'b0;
        #1 chk("ready_after_rst", {31'd0, bus.o_req_ready}, 32'd1);

        store_chk("st_w10", 2'd2, 32'h10, 32'hDEAD_BEEF, 32'd4, 4'b1111, 32'hDEAD_BEEF);
        store_chk("st_b13", 2'd0, 32'h13, 32'h0000_00A5, 32'd4, 4'b1000, 32'hA5A5_A5A5);
        chk("mem4_byte", mem[4], 32'hA5AD_BEEF);
        load_chk("ld_bs13", 2'd0, 32'h13, 1'b0, 32'hFFFF_FFA5);
        load_chk("ld_bu13", 2'd0, 32'h13, 1'b1, 32'h0000_00A5);

        store_chk("st_w10b", 2'd2, 32'h10, 32'hDEAD_BEEF, 32'd4, 4'b1111, 32'hDEAD_BEEF);
        load_chk("ld_hs12", 2'd1, 32'h12, 1'b0, 32'hFFFF_DEAD);
        load_chk("ld_hu10", 2'd1, 32'h10, 1'b1, 32'h0000_BEEF);
        load_chk("ld_hs10", 2'd1, 32'h10, 1'b0, 32'hFFFF_BEEF);
        load_chk("ld_w10", 2'd2, 32'h10, 1'b1, 32'hDEAD_BEEF);
        load_chk("ld_bs11", 2'd0, 32'h11, 1'b0, 32'hFFFF_FFBE);
        load_chk("ld_bu12", 2'd0, 32'h12, 1'b1, 32'h0000_00AD);

        store_chk("st_h16", 2'd1, 32'h16, 32'hFFFF_1234, 32'd5, 4'b1100, 32'h1234_1234);
        load_chk("ld_w14", 2'd2, 32'h14, 1'b0, 32'h1234_0000);
        load_chk("ld_bs17", 2'd0, 32'h17, 1'b0, 32'h0000_0012);

        err_chk("err_w12", 1'b1, 2'd2, 32'h12, 32'd5);
        err_chk("err_oor", 1'b1, 2'd2, 32'h400, 32'd5);
        err_chk("err_sz3", 1'b0, 2'd3, 32'h10, 32'd5);
        err_chk("err_h11", 1'b1, 2'd1, 32'h11, 32'd5);
        err_chk("err_boor", 1'b1, 2'd0, 32'h8000_0800, 32'd5);
        chk("mem4_intact", mem[4], 32'hDEAD_BEEF);

        // Back-pressured load with a competing request held valid.
        bus.i_rsp_ready = 1'b0;
        req(1'b0, 2'd2, 32'h10, 32'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("bp_valid0", {31'd0, bus.o_rsp_valid}, 32'd1);
        chk("bp_rdata0", bus.o_rsp_rdata, 32'hDEAD_BEEF);
        bus.i_req_valid = 1'b1;
        bus.i_req_write = 1'b1;
        bus.i_req_size  = 2'd2;
        bus.i_req_addr  = 32'h14;
        bus.i_req_wdata = 32'h55AA_55AA;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, bus.o_rsp_valid}, 32'd1);
            chk("bp_rdata", bus.o_rsp_rdata, 32'hDEAD_BEEF);
            chk("bp_err", {31'd0, bus.o_rsp_error}, 32'd0);
            chk("bp_ready", {31'd0, bus.o_req_ready}, 32'd0);
        end
        bus.i_rsp_ready = 1'b1;
        #1 chk("hs_ready", {31'd0, bus.o_req_ready}, 32'd0);
        @(negedge clk);
        chk("post_hs_valid", {31'd0, bus.o_rsp_valid}, 32'd0);
        chk("post_hs_ready", {31'd0, bus.o_req_ready}, 32'd1);
        @(negedge clk);
        bus.i_req_valid = 1'b0;
        chk("bp_st_ready", {31'd0, bus.o_req_ready}, 32'd0);
        chk("bp_st_strb", {28'd0, bus.o_tcm_write}, 32'hF);
        chk("bp_st_data", bus.o_tcm_data, 32'h55AA_55AA);
        @(negedge clk);
        chk("bp_st_valid", {31'd0, bus.o_rsp_valid}, 32'd1);
        @(negedge clk);
        load_chk("ld_w14b", 2'd2, 32'h14, 1'b0, 32'h55AA_55AA);

        // Reset while the load is in CAPTURE.
        req(1'b0, 2'd2, 32'h10, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_valid", {31'd0, bus.o_rsp_valid}, 32'd0);
        chk("abort_strb", {28'd0, bus.o_tcm_write}, 32'd0);
        chk("abort_ready", {31'd0, bus.o_req_ready}, 32'd1);
        chk("abort_rdata", bus.o_rsp_rdata, 32'd0);
        chk("abort_addr", {24'd0, bus.o_tcm_addr}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort_quiet", {31'd0, bus.o_rsp_valid}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
